// File: rtl/shared_resource_arbiter.sv
// Round-robin / time-division arbiter sharing one fixed-latency resource between
// N_REQ requesters; only one transaction is ever in flight.
module shared_resource_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int RES_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tdm_en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic [DATA_W-1:0]       res_input,
    input  logic [DATA_W-1:0]       res_output,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (RES_LATENCY > 1) ? $clog2(RES_LATENCY) : 1;
    localparam logic [IDX_W:0]   N_REQ_EXT = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RES_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_rrPtr;
    logic [IDX_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_counter;
    logic              r_dummy;
    logic [DATA_W-1:0] r_resInput;
    logic [DATA_W-1:0] r_respData;
    logic [N_REQ-1:0]  r_respValid;

    logic [DATA_W-1:0] w_reqWord [N_REQ];
    logic [IDX_W:0]    w_cand;
    logic              w_grantFound;
    logic [IDX_W-1:0]  w_grantIdx;
    logic [IDX_W-1:0]  w_selIdx;
    logic [DATA_W-1:0] w_selData;
    logic              w_slotValid;
    logic              w_launch;
    logic              w_handshake;

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_reqWord[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // First valid requester searching upward from the round-robin pointer.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rrPtr} + (IDX_W+1)'(k);
            if (w_cand >= N_REQ_EXT) begin
                w_cand = w_cand - N_REQ_EXT;
            end
            if (!w_grantFound && req_valid[w_cand[IDX_W-1:0]]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = w_cand[IDX_W-1:0];
            end
        end
    end

    // In TDM mode the slot owner is fixed by the pointer and a slot is spent even when unused.
    always_comb begin
        w_slotValid = req_valid[r_rrPtr];
        w_selIdx    = tdm_en ? r_rrPtr : w_grantIdx;
        w_selData   = w_reqWord[w_selIdx];
        w_launch    = (r_state == IDLE) && (tdm_en || w_grantFound);
        w_handshake = (r_state == IDLE) && (tdm_en ? w_slotValid : w_grantFound);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_counter == '0) begin
                    w_nextState = RESP;
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (r_state != IDLE);
        if (r_state == IDLE) begin
            if (tdm_en) begin
                req_ready[r_rrPtr] = w_slotValid;
            end else if (w_grantFound) begin
                req_ready[w_grantIdx] = 1'b1;
            end
        end
    end

    // res_input only moves on a real handshake; a dummy slot leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rrPtr     <= '0;
            r_owner     <= '0;
            r_counter   <= '0;
            r_dummy     <= 1'b0;
            r_resInput  <= '0;
            r_respData  <= '0;
            r_respValid <= '0;
        end else begin
            r_respValid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_owner   <= w_selIdx;
                        r_rrPtr   <= nextIdx(w_selIdx);
                        r_counter <= CNT_LOAD;
                        r_dummy   <= !w_handshake;
                        if (w_handshake) begin
                            r_resInput <= w_selData;
                        end
                    end
                end
                WAIT: begin
                    if (r_counter != '0) begin
                        r_counter <= r_counter - 1'b1;
                    end
                end
                RESP: begin
                    r_respData <= res_output;
                    if (!r_dummy) begin
                        r_respValid[r_owner] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_input  = r_resInput;
    assign resp_data  = r_respData;
    assign resp_valid = r_respValid;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Scoreboard bench for shared_resource_arbiter: directed requests push expected
// responses, a negedge monitor pops and compares each resp_valid pulse.
module tb_shared_resource_arbiter;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 32;
    localparam int RES_LATENCY = 1;

    logic                    clk       = 1'b0;
    logic                    reset     = 1'b0;
    logic                    tdm_en    = 1'b0;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data  = '0;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_data;
    logic [DATA_W-1:0]       res_input;
    logic [DATA_W-1:0]       res_output;
    logic                    busy;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cycleCnt = 0;

    shared_resource_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_W     (DATA_W),
        .RES_LATENCY(RES_LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tdm_en    (tdm_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .res_input (res_input),
        .res_output(res_output),
        .busy      (busy)
    );

    // Resource model: combinational +10000, valid well within one cycle.
    assign res_output = res_input + 32'd10000;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [3:0] oneHot(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Raise a request and record the response the resource should return for it.
    task automatic applyStimulus(input int i, input logic [31:0] d);
        exp_t e;
        req_data[i*DATA_W +: DATA_W] = d;
        req_valid[i] = 1'b1;
        e.idx  = i;
        e.data = d + 32'd10000;
        expQ.push_back(e);
    endtask

    // Called between posedge+1 and the next negedge; returns at handshake edge +1.
    task automatic waitGrant(input logic [3:0] expReady, output int hsCycle);
        logic [3:0] seen;
        int         n;
        seen    = '0;
        n       = 0;
        hsCycle = -1;
        while (seen == '0 && n < 40) begin
            @(negedge clk);
            seen = req_ready;
            n++;
        end
        checkOutput("grant", 64'(seen), 64'(expReady));
        if (seen != '0) begin
            @(posedge clk);
            #1;
            hsCycle   = cycleCnt;
            req_valid = req_valid & ~seen;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (resp_valid !== '0) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_resp: got valid=%b data=%0d, expected no response",
                         resp_valid, resp_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("resp_valid", 64'(resp_valid), 64'(oneHot(e.idx)));
                checkOutput("resp_data", 64'(resp_data), 64'(e.data));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int hs[4];
        int hsA;
        int hsB;
        int rel;
        int busyCnt;
        logic [3:0] anyReady;
        logic       anyRes;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_res_input", 64'(res_input), 64'(0));
        checkOutput("rst_resp_data", 64'(resp_data), 64'(0));
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single request, exact timing
        applyStimulus(0, 32'd5);
        waitGrant(4'b0001, hsA);
        checkOutput("t1_res_input", 64'(res_input), 64'(5));
        checkOutput("t1_busy_e0", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("t1_busy_e1", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        checkOutput("t1_busy_e2", 64'(busy), 64'(0));
        checkOutput("t1_resp_valid_e2", 64'(resp_valid), 64'(4'b0001));
        checkOutput("t1_resp_data_e2", 64'(resp_data), 64'(10005));
        waitDrain();

        // Full contention after reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(i, 32'(i + 1));
        for (int i = 0; i < 4; i++) begin
            waitGrant(oneHot(i), hs[i]);
            if (i > 0) checkOutput("contend_spacing", 64'(hs[i] - hs[i-1]), 64'(3));
        end
        waitDrain();

        // Fairness: last grant to 2, then 1 and 3 contend
        applyStimulus(2, 32'd6);
        waitGrant(4'b0100, hsA);
        waitDrain();
        applyStimulus(3, 32'd23);
        applyStimulus(1, 32'd21);
        waitGrant(4'b1000, hsA);
        waitGrant(4'b0010, hsB);
        waitDrain();

        // TDM from reset release with only requester 2 active
        @(negedge clk);
        reset  = 1'b0;
        tdm_en = 1'b1;
        applyStimulus(2, 32'd7);
        @(negedge clk);
        reset = 1'b1;
        rel   = cycleCnt;
        checkOutput("tdm_slot0_ready", 64'(req_ready), 64'(0));
        busyCnt  = 0;
        anyReady = '0;
        anyRes   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            busyCnt  += int'(busy);
            anyReady |= req_ready;
            anyRes   |= (res_input != '0);
        end
        checkOutput("tdm_dummy_busy", 64'(busyCnt), 64'(4));
        checkOutput("tdm_dummy_ready", 64'(anyReady), 64'(0));
        checkOutput("tdm_dummy_res_input", 64'(anyRes), 64'(0));
        waitGrant(4'b0100, hsA);
        checkOutput("tdm_hs_cycle", 64'(hsA - rel), 64'(7));
        tdm_en = 1'b0;
        applyStimulus(3, 32'd13);
        applyStimulus(1, 32'd11);
        waitGrant(4'b1000, hsA);
        waitGrant(4'b0010, hsB);
        waitDrain();

        // Reset during WAIT drops the transaction
        req_data[0 +: DATA_W] = 32'd9;
        req_valid[0] = 1'b1;
        waitGrant(4'b0001, hsA);
        reset = 1'b0;
        #1;
        checkOutput("midrst_res_input", 64'(res_input), 64'(0));
        checkOutput("midrst_busy", 64'(busy), 64'(0));
        checkOutput("midrst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("midrst_req_ready", 64'(req_ready), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1, 32'd41);
        applyStimulus(3, 32'd43);
        waitGrant(4'b0010, hsA);
        waitGrant(4'b1000, hsB);
        waitDrain();

        // New request arriving in the cycle resp_valid pulses
        applyStimulus(0, 32'd20);
        waitGrant(4'b0001, hsA);
        @(posedge clk);
        @(posedge clk);
        #1;
        applyStimulus(3, 32'd30);
        @(negedge clk);
        checkOutput("simul_req_ready", 64'(req_ready), 64'(4'b1000));
        checkOutput("simul_resp_valid", 64'(resp_valid), 64'(4'b0001));
        @(posedge clk);
        #1;
        hsB = cycleCnt;
        req_valid[3] = 1'b0;
        checkOutput("simul_spacing", 64'(hsB - hsA), 64'(3));
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shared_resource_arbiter.md
Name: shared_resource_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `shared_resource` instance between N_REQ requesters.
- Accepts one request at a time via valid/ready and drives the resource input from a register.
- Waits the resource's fixed latency, then returns the captured result to the owning requester.
- Optional time-division (TDM) mode gives every requester a fixed-length slot, used or not, so response timing reveals nothing about other requesters' activity.

Parameters:
N_REQ, 4, number of requesters (2..8); index width IDX_W = clog2(N_REQ)
DATA_W, 32, request/response/resource data width
RES_LATENCY, 1, cycles from res_input change to valid res_output (>=1)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
tdm_en  input  1  1 = time-division slot mode, 0 = work-conserving round-robin; sampled only in IDLE
req_valid  input  N_REQ  per-requester request valid; must stay high with stable data until handshake
req_data  input  N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  one-hot or zero; high only for the currently granted requester in IDLE
resp_valid  output  N_REQ  one-hot, single-cycle pulse to the owning requester
resp_data  output  DATA_W  result, qualified by resp_valid; holds last value otherwise
res_input  output  DATA_W  registered drive to the resource
res_output  input  DATA_W  result from the resource
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, owner=0, counter=0, dummy=0. Outputs: res_input=0, resp_data=0, resp_valid=0, req_ready=0, busy=0. An in-flight transaction is dropped and no response is issued.
- States: IDLE, WAIT, RESP.
- IDLE, tdm_en=0 (round-robin):
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[g]=1 combinationally; no grant and req_ready=0 if no requests.
  - On handshake at edge E0: res_input<=req_data[g], owner<=g, rr_ptr<=(g+1) mod N_REQ, counter<=RES_LATENCY-1, dummy<=0, state->WAIT.
- IDLE, tdm_en=1 (TDM): only slot s=rr_ptr is eligible; req_ready[s]=req_valid[s].
  - If req_valid[s]=1: handshake exactly as above.
  - If req_valid[s]=0: dummy<=1, owner<=s, res_input unchanged, state->WAIT.
  - rr_ptr<=(s+1) mod N_REQ in both cases, so every slot takes identical time.
- WAIT: if counter==0, state->RESP; else counter decrements.
- RESP: at the exiting edge, resp_data<=res_output and resp_valid[owner]<=1 for one cycle (suppressed if dummy=1). State->IDLE.
- Timing for a real transaction:
  - resp_valid is high in the cycle after edge E0+RES_LATENCY+1.
  - The next handshake can occur at the earliest at edge E0+RES_LATENCY+2, so max throughput is one transaction per RES_LATENCY+2 cycles.
  - A new grant may handshake in the same cycle that resp_valid is high.
- No response backpressure: requesters must accept a resp_valid pulse.
- res_input holds its value between transactions. It is never changed outside a handshake edge.
- Only one transaction is ever outstanding.
- Changing tdm_en outside IDLE has no effect until the next IDLE cycle.
- A requester dropping req_valid before handshake is a protocol violation; the arbiter must not hang and simply re-arbitrates.
- rr_ptr wraps from N_REQ-1 to 0.

Test Plan:
- Single request, RES_LATENCY=1, resource adds 10000: req_valid[0]=1, data=5, handshake at E0 -> res_input=5 after E0; resp_valid=4'b0001 with resp_data=10005 in the cycle after E0+2; busy high for 2 cycles.
- Full contention after reset: all 4 valid with data 1,2,3,4 held until handshake -> grants 0,1,2,3 at 3-cycle spacing; responses 10001, 10002, 10003, 10004 to the matching one-hot resp_valid.
- Fairness: after the last grant went to requester 2, requesters 1 and 3 valid -> 3 granted first, then 1 (rr_ptr wraps through 0).
- TDM: tdm_en=1, only req_valid[2]=1 (data=7) from reset release -> slots 0 and 1 are dummies (3 cycles each, no resp_valid, res_input stays 0); handshake at the start of the third slot; resp 10007 to requester 2; rr_ptr then 3.
- Reset mid-operation: assert reset low during WAIT -> all outputs 0 immediately, no resp_valid after release; the next request from requester 1 is granted with rr_ptr starting at 0.
- Simultaneous events: req_valid[3] rises in the RESP-to-IDLE cycle while resp_valid[0] pulses -> req_ready[3]=1 in that same cycle and handshake proceeds; the response to 0 is unaffected.
